alu_operand_loader: RTL and testbench

Front-end stage feeding the ALU on the development board. It latches operand A, operand B and the operation code from the slide switches under control of three push-buttons. Each button is synchronized, debounced and edge-detected. The three registers drive the ALU's `i_dato_a`, `i_dato_b` and `i_ope_sel` inputs directly.

---
 rtl/alu_loader_pkg.sv | 9 +
 rtl/btn_debouncer.sv | 37 +++
 rtl/alu_operand_loader.sv | 52 +++++
 tb/tb_alu_operand_loader.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_loader_pkg.sv
// alu_loader_pkg: shared constants and types for the ALU operand loader
package alu_loader_pkg;
  localparam int BTN_A = 0;
  localparam int BTN_B = 1;
  localparam int BTN_OP = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int SIM_DEBOUNCE_CYCLES = 4;
  typedef enum logic {STABLE_LOW, STABLE_HIGH} lvl_t;
endpackage

// File: rtl/btn_debouncer.sv
// btn_debouncer: synchronizes, debounces and rising-edge-detects one push-button
module btn_debouncer
  import alu_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_pulse
);
  localparam int NB_CNT = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(DEBOUNCE_CYCLES - 1);
  logic [1:0] r_sync;
  logic [NB_CNT-1:0] r_cnt;
  lvl_t r_lvl;
  logic r_pulse;
  logic w_diff;
  logic w_flip;
  assign w_diff = r_sync[1] ^ (r_lvl == STABLE_HIGH);
  assign w_flip = w_diff && (r_cnt == CNT_LAST);
  assign o_pulse = r_pulse;
  // sync chain, stability counter, level FSM and a pulse on the low-to-high flip
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_cnt <= '0;
      r_lvl <= STABLE_LOW;
      r_pulse <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
      r_cnt <= (w_diff && !w_flip) ? r_cnt + 1'b1 : '0;
      if (w_flip) r_lvl <= (r_lvl == STABLE_LOW) ? STABLE_HIGH : STABLE_LOW;
      r_pulse <= w_flip && (r_lvl == STABLE_LOW);
    end
  end
endmodule

// File: rtl/alu_operand_loader.sv
// alu_operand_loader: latches ALU operands and op-code from switches on debounced button presses
module alu_operand_loader
  import alu_loader_pkg::*;
#(
  parameter int NB_BITS = 8,
  parameter int NB_OPE = 6,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NB_BITS-1:0] i_sw,
  input  logic [2:0]         i_btn,
  output logic [NB_BITS-1:0] o_dato_a,
  output logic [NB_BITS-1:0] o_dato_b,
  output logic [NB_OPE-1:0]  o_ope_sel,
  output logic               o_valid
);
  logic [2:0] w_pulse;
  logic [2:0] r_ld;
  logic [NB_BITS-1:0] r_dato_a;
  logic [NB_BITS-1:0] r_dato_b;
  logic [NB_OPE-1:0] r_ope_sel;
  logic r_valid;
  for (genvar g = 0; g < 3; g++) begin : g_btn
    btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_btn  (i_btn[g]),
      .o_pulse(w_pulse[g])
    );
  end
  assign o_dato_a = r_dato_a;
  assign o_dato_b = r_dato_b;
  assign o_ope_sel = r_ope_sel;
  assign o_valid = r_valid;
  // load registers on their pulses; valid rises with the last first-load and sticks
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dato_a <= '0;
      r_dato_b <= '0;
      r_ope_sel <= '0;
      r_ld <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_pulse[BTN_A]) r_dato_a <= i_sw;
      if (w_pulse[BTN_B]) r_dato_b <= i_sw;
      if (w_pulse[BTN_OP]) r_ope_sel <= i_sw[NB_OPE-1:0];
      r_ld <= r_ld | w_pulse;
      r_valid <= &(r_ld | w_pulse);
    end
  end
endmodule

// File: tb/tb_alu_operand_loader.sv
// tb_alu_operand_loader: scoreboard bench for the ALU operand loader
module tb_alu_operand_loader;
  import alu_loader_pkg::*;
  typedef struct {
    int edge_n;
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic v;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] sw = 8'hFF;
  logic [2:0] btn = 3'b000;
  logic [7:0] o_dato_a;
  logic [7:0] o_dato_b;
  logic [5:0] o_ope_sel;
  logic o_valid;
  exp_t sbq[$];
  int edges = 0;
  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;
  logic [7:0] m_a = '0;
  logic [7:0] m_b = '0;
  logic [5:0] m_op = '0;
  logic [2:0] m_f = '0;
  logic [22:0] prev = '0;

  alu_operand_loader #(.NB_BITS(8), .NB_OPE(6), .DEBOUNCE_CYCLES(SIM_DEBOUNCE_CYCLES)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_sw(sw), .i_btn(btn),
    .o_dato_a(o_dato_a), .o_dato_b(o_dato_b), .o_ope_sel(o_ope_sel), .o_valid(o_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges++;

  always @(posedge clk) begin
    logic [22:0] cur;
    exp_t e;
    #2;
    cur = {o_dato_a, o_dato_b, o_ope_sel, o_valid};
    if (mon_en && cur !== prev) begin
      n_cmp++;
      if (sbq.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_change got=%h at edge %0d", cur, edges);
      end else begin
        e = sbq.pop_front();
        if (edges != e.edge_n || cur !== {e.a, e.b, e.op, e.v}) begin
          n_err++;
          $display("FAIL load_event got=%h@%0d want=%h@%0d", cur, edges, {e.a, e.b, e.op, e.v}, e.edge_n);
        end
      end
    end
    prev = cur;
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_load(int e, logic [2:0] which, logic [7:0] v);
    if (which[BTN_A]) m_a = v;
    if (which[BTN_B]) m_b = v;
    if (which[BTN_OP]) m_op = v[5:0];
    m_f = m_f | which;
    sbq.push_back('{e, m_a, m_b, m_op, &m_f});
  endtask

  task automatic model_reset();
    m_a = '0; m_b = '0; m_op = '0; m_f = '0;
    sbq.delete();
  endtask

  task automatic wait_drain(string name, int limit);
    int k = 0;
    while (sbq.size() != 0 && k < limit) begin
      tick(1);
      k++;
    end
    n_cmp++;
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL %s_timeout pending=%0d want=0", name, sbq.size());
      sbq.delete();
    end
    tick(6);
  endtask

  task automatic check_outs(string name);
    n_cmp++;
    if ({o_dato_a, o_dato_b, o_ope_sel, o_valid} !== {m_a, m_b, m_op, &m_f}) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", name, {o_dato_a, o_dato_b, o_ope_sel, o_valid}, {m_a, m_b, m_op, &m_f});
    end
  endtask

  task automatic press(logic [2:0] b, logic [7:0] v, int hold);
    @(negedge clk);
    sw = v;
    btn = b;
    expect_load(edges + 7, b, v);
    tick(hold);
    btn = 3'b000;
  endtask

  task automatic test_reset();
    tick(2);
    check_outs("reset_held");
    rst_n = 1'b1;
    mon_en = 1'b1;
    tick(8);
    check_outs("reset_released_idle");
    #2;
    rst_n = 1'b0;
    mon_en = 1'b0;
    #1;
    check_outs("reset_async");
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    tick(4);
    check_outs("reset_idle_again");
  endtask

  task automatic test_clean_load();
    @(negedge clk);
    sw = 8'h2A;
    btn[BTN_A] = 1'b1;
    expect_load(edges + 7, 3'b001, 8'h2A);
    tick(10);
    sw = 8'h55;
    tick(10);
    btn = 3'b000;
    wait_drain("clean_load", 20);
    check_outs("clean_load_held_once");
  endtask

  task automatic test_bounce();
    int hi[3] = '{1, 2, 3};
    @(negedge clk);
    sw = 8'h3C;
    foreach (hi[i]) begin
      btn[BTN_B] = 1'b1;
      tick(hi[i]);
      btn[BTN_B] = 1'b0;
      tick(1);
    end
    tick(10);
    check_outs("bounce_rejected");
    press(3'b010, 8'h3C, 10);
    wait_drain("bounce_hold", 20);
    check_outs("bounce_hold_loaded");
  endtask

  task automatic test_op_valid();
    press(3'b100, 8'hE2, 10);
    wait_drain("op_load", 20);
    check_outs("op_trunc_valid");
    n_cmp++;
    if (o_ope_sel !== 6'b100010 || o_valid !== 1'b1) begin
      n_err++;
      $display("FAIL op_value got=%b/%b want=100010/1", o_ope_sel, o_valid);
    end
  endtask

  task automatic test_simultaneous();
    press(3'b011, 8'h81, 12);
    wait_drain("simultaneous", 20);
    check_outs("simultaneous_ab");
  endtask

  task automatic test_reset_mid_debounce();
    @(negedge clk);
    sw = 8'h17;
    btn[BTN_OP] = 1'b1;
    tick(2);
    rst_n = 1'b0;
    mon_en = 1'b0;
    model_reset();
    #1;
    check_outs("mid_reset_cleared");
    tick(3);
    check_outs("mid_reset_no_load");
    rst_n = 1'b1;
    mon_en = 1'b1;
    expect_load(edges + 7, 3'b100, 8'h17);
    tick(12);
    btn = 3'b000;
    wait_drain("mid_reset_reload", 20);
    check_outs("mid_reset_single_load");
  endtask

  initial begin
    test_reset();
    test_clean_load();
    test_bounce();
    test_op_valid();
    test_simultaneous();
    test_reset_mid_debounce();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
